fetch_stage: RTL

- Instruction-fetch stage: owns the PC, reads the instruction memory and fills the IF/ID pipeline register that the decode stage / control unit consumes.
- Handles the reset-vector load, two-word instructions (instruction word followed by a 16-bit immediate word), pipeline stall, and branch/call/return redirect from downstream stages.
- The registered 9-bit opcode feeds the control unit's opcode input directly.

---
 rtl/fetch_stage.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, walks one- and two-word instructions out of
// instruction memory and fills the IF/ID register consumed by decode / control.
module fetch_stage #(
  parameter int PC_W           = 32,
  parameter int RESET_VEC_ADDR = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            if_id_valid,
  output logic [8:0]      if_id_opcode,
  output logic [2:0]      if_id_rdst,
  output logic [2:0]      if_id_rsrc,
  output logic            if_id_has_imm,
  output logic [15:0]     if_id_imm,
  output logic [PC_W-1:0] if_id_pc_next
);

  typedef enum logic [1:0] {
    ST_RST_VEC = 2'd0,
    ST_FETCH   = 2'd1,
    ST_IMM     = 2'd2
  } state_e;

  typedef struct packed {
    logic            valid;
    logic [8:0]      opcode;
    logic [2:0]      rdst;
    logic [2:0]      rsrc;
    logic            has_imm;
    logic [15:0]     imm;
    logic [PC_W-1:0] pc_next;
  } if_id_t;

  localparam logic [PC_W-1:0] RstVecAddr = PC_W'(RESET_VEC_ADDR);
  localparam logic [PC_W-1:0] PcOne      = PC_W'(1);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     instr_hold_q, instr_hold_d;
  if_id_t          if_id_q, if_id_d;
  logic [PC_W-1:0] pc_inc;

  assign pc_inc = pc_q + PcOne;

  always_comb begin
    imem_addr = pc_q;
    if (state_q == ST_RST_VEC) begin
      imem_addr = RstVecAddr;
    end
  end

  // NOTE: every next-state signal gets its hold value first, so no path through
  // the case below can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_hold_d = instr_hold_q;
    if_id_d      = if_id_q;

    unique case (state_q)
      ST_RST_VEC: begin
        // Redirects cannot be meaningful before the first PC exists.
        if (!stall) begin
          pc_d          = PC_W'(imem_data);
          state_d       = ST_FETCH;
          if_id_d.valid = 1'b0;
        end
      end

      ST_FETCH, ST_IMM: begin
        if (redirect) begin
          // Squash wins over stall and over a pending immediate word.
          pc_d          = redirect_pc;
          state_d       = ST_FETCH;
          instr_hold_d  = '0;
          if_id_d.valid = 1'b0;
        end else if (!stall) begin
          pc_d = pc_inc;
          if (state_q == ST_FETCH && imem_data[0]) begin
            instr_hold_d  = imem_data;
            state_d       = ST_IMM;
            if_id_d.valid = 1'b0;
          end else if (state_q == ST_FETCH) begin
            if_id_d.valid   = 1'b1;
            if_id_d.opcode  = imem_data[15:7];
            if_id_d.rdst    = imem_data[6:4];
            if_id_d.rsrc    = imem_data[3:1];
            if_id_d.has_imm = 1'b0;
            if_id_d.imm     = '0;
            if_id_d.pc_next = pc_inc;
          end else begin
            if_id_d.valid   = 1'b1;
            if_id_d.opcode  = instr_hold_q[15:7];
            if_id_d.rdst    = instr_hold_q[6:4];
            if_id_d.rsrc    = instr_hold_q[3:1];
            if_id_d.has_imm = 1'b1;
            if_id_d.imm     = imem_data;
            if_id_d.pc_next = pc_inc;
            state_d         = ST_FETCH;
          end
        end
      end

      default: begin
        state_d = ST_RST_VEC;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample
  // the same pre-edge values; the hold register is reset too, so a reset in the
  // middle of a two-word instruction leaves nothing stale behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RST_VEC;
      pc_q         <= '0;
      instr_hold_q <= '0;
      if_id_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_hold_q <= instr_hold_d;
      if_id_q      <= if_id_d;
    end
  end

  assign if_id_valid   = if_id_q.valid;
  assign if_id_opcode  = if_id_q.opcode;
  assign if_id_rdst    = if_id_q.rdst;
  assign if_id_rsrc    = if_id_q.rsrc;
  assign if_id_has_imm = if_id_q.has_imm;
  assign if_id_imm     = if_id_q.imm;
  assign if_id_pc_next = if_id_q.pc_next;

endmodule
